// File: rtl/pq_batch_sorter.sv
// Streaming batch sorter built around an attached priority queue.
// Loads a batch of {key,val} beats into the PQ, then drains it in ascending key order.
module pq_batch_sorter #(
  parameter int unsigned KEY_WIDTH   = 8,
  parameter int unsigned VAL_WIDTH   = 8,
  parameter int unsigned PQ_CAPACITY = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] in_kv,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] out_kv,
  output logic                           out_last,
  output logic                           pq_enq,
  output logic                           pq_deq,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvi,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvo,
  input  logic                           pq_full,
  input  logic                           pq_empty,
  input  logic                           pq_busy,
  output logic                           err_trunc,
  output logic                           busy
);

  localparam int unsigned CNT_W = $clog2(PQ_CAPACITY + 1);
  localparam logic [CNT_W-1:0] CAP    = CNT_W'(PQ_CAPACITY);
  localparam logic [CNT_W-1:0] CAP_M1 = CNT_W'(PQ_CAPACITY - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic {
    S_LOAD  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and PQ command decode; in_ready is forced low while reset is held
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    pq_enq   = 1'b0;
    pq_deq   = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        in_ready = rst && !pq_busy && !pq_full && (count_q < CAP);
        pq_enq   = in_valid && in_ready;
        if (pq_enq && (in_last || (count_q == CAP_M1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        pq_deq = (count_q != '0) && !pq_busy && !pq_empty && (!out_valid || out_ready);
        if (out_valid && out_ready && out_last) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign pq_kvi = in_kv;
  assign busy   = !((state_q == S_LOAD) && (count_q == '0));

  // Batch counter, truncation flag and one-entry output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_kv    <= '0;
      err_trunc <= 1'b0;
    end else begin
      if (pq_enq) begin
        count_q <= count_q + ONE;
        if (count_q == '0) begin
          err_trunc <= 1'b0;
        end
        // Filling the PQ without a last beat ends the batch early
        if (!in_last && (count_q == CAP_M1)) begin
          err_trunc <= 1'b1;
        end
      end
      if (pq_deq) begin
        out_kv    <= pq_kvo;
        out_valid <= 1'b1;
        out_last  <= (count_q == ONE);
        count_q   <= count_q - ONE;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pq_batch_sorter.sv
// Bench for pq_batch_sorter with a behavioural priority queue attached.
module tb_pq_batch_sorter;

  localparam int KW  = 8;
  localparam int VW  = 8;
  localparam int KVW = KW + VW;
  localparam int CAP = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [KVW-1:0] in_kv = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [KVW-1:0] out_kv;
  logic           out_last;
  logic           pq_enq;
  logic           pq_deq;
  logic [KVW-1:0] pq_kvi;
  logic [KVW-1:0] pq_kvo;
  logic           pq_full;
  logic           pq_empty;
  logic           pq_busy = 1'b0;
  logic           err_trunc;
  logic           busy;

  always #5 clk = ~clk;

  pq_batch_sorter #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .PQ_CAPACITY(CAP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kv(in_kv), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_kv(out_kv), .out_last(out_last),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
    .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy),
    .err_trunc(err_trunc), .busy(busy)
  );

  // Behavioural PQ: unordered store, head is the lowest key (earliest among ties)
  logic [KVW-1:0] pq_mem [CAP];
  int pq_n;
  int min_idx;

  always @* begin
    min_idx = 0;
    for (int i = 1; i < CAP; i++) begin
      if (i < pq_n && pq_mem[i][KVW-1:VW] < pq_mem[min_idx][KVW-1:VW]) min_idx = i;
    end
  end

  assign pq_kvo   = (pq_n > 0) ? pq_mem[min_idx] : '0;
  assign pq_empty = (pq_n == 0);
  assign pq_full  = (pq_n >= CAP);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pq_n <= 0;
    end else if (pq_enq && pq_n < CAP) begin
      pq_mem[pq_n] <= pq_kvi;
      pq_n <= pq_n + 1;
    end else if (pq_deq && pq_n > 0) begin
      for (int i = 0; i < CAP - 1; i++) begin
        if (i >= min_idx) pq_mem[i] <= pq_mem[i + 1];
      end
      pq_n <= pq_n - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [KVW-1:0] oq_kv [$];
  logic           oq_last [$];
  int             oq_cyc [$];
  int             last_hs_cyc;

  logic           snap_in_ready, snap_pq_enq, snap_pq_deq, snap_out_valid, snap_err, snap_busy;
  logic [KVW-1:0] snap_out_kv;
  logic           prev_hold = 1'b0;
  logic [KVW-1:0] prev_kv;
  logic           prev_last;
  int             snap_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // One clock: sample and monitor at the falling edge, return just after the rising edge
  task automatic step();
    @(negedge clk);
    snap_cyc       = cyc;
    snap_in_ready  = in_ready;
    snap_pq_enq    = pq_enq;
    snap_pq_deq    = pq_deq;
    snap_out_valid = out_valid;
    snap_out_kv    = out_kv;
    snap_err       = err_trunc;
    snap_busy      = busy;
    if (rst) begin
      check("enq_deq_exclusive", 32'(pq_enq && pq_deq), 0);
      if (pq_enq) check("enq_legal", 32'(pq_busy || pq_full), 0);
      if (pq_enq) check("kvi_passthrough", 32'(pq_kvi), 32'(in_kv));
      if (pq_deq) check("deq_legal", 32'(pq_busy || pq_empty), 0);
      if (out_valid) check("in_ready_in_drain", 32'(in_ready), 0);
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_kv", 32'(out_kv), 32'(prev_kv));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && !out_ready) check("no_deq_in_stall", 32'(pq_deq), 0);
      prev_hold = out_valid && !out_ready;
      prev_kv   = out_kv;
      prev_last = out_last;
      if (out_valid && out_ready) begin
        oq_kv.push_back(out_kv);
        oq_last.push_back(out_last);
        oq_cyc.push_back(cyc);
      end
    end else begin
      prev_hold = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [KVW-1:0] kv, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_kv    = kv;
    in_last  = last;
    forever begin
      step();
      if (snap_in_ready) begin
        last_hs_cyc = snap_cyc;
        break;
      end
      t++;
      if (t > 200) begin
        timeout_fail("send");
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int t;
    t = 0;
    while (oq_kv.size() < n) begin
      step();
      t++;
      if (t > 300) begin
        timeout_fail("wait_outputs");
        break;
      end
    end
  endtask

  task automatic clear_q();
    oq_kv.delete();
    oq_last.delete();
    oq_cyc.delete();
  endtask

  typedef struct packed {
    logic [2:0]            n;
    logic [0:4][KVW-1:0]   in_kv;
    logic [0:4][KVW-1:0]   exp_kv;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{n: 3'd5,
                in_kv:  {16'h090A, 16'h030B, 16'h070C, 16'h010D, 16'h050E},
                exp_kv: {16'h010D, 16'h030B, 16'h050E, 16'h070C, 16'h090A}};
    vecs[1] = '{n: 3'd1,
                in_kv:  {16'h2A55, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                exp_kv: {16'h2A55, 16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    vecs[2] = '{n: 3'd3,
                in_kv:  {16'h0111, 16'h0222, 16'h0333, 16'h0000, 16'h0000},
                exp_kv: {16'h0111, 16'h0222, 16'h0333, 16'h0000, 16'h0000}};
    vecs[3] = '{n: 3'd4,
                in_kv:  {16'hC801, 16'h9602, 16'h6403, 16'h3204, 16'h0000},
                exp_kv: {16'h3204, 16'h6403, 16'h9602, 16'hC801, 16'h0000}};
    vecs[4] = '{n: 3'd3,
                in_kv:  {16'hFF07, 16'h0008, 16'h8009, 16'h0000, 16'h0000},
                exp_kv: {16'h0008, 16'h8009, 16'hFF07, 16'h0000, 16'h0000}};

    // Reset values, with in_valid high to show the handshake is blocked
    in_valid = 1'b1;
    in_kv    = 16'h1234;
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_kv", 32'(out_kv), 0);
    check("rst_err_trunc", 32'(err_trunc), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_pq_enq", 32'(pq_enq), 0);
    check("rst_pq_deq", 32'(pq_deq), 0);
    check("rst_busy", 32'(busy), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;

    // Table-driven batches with an always-ready sink
    for (int v = 0; v < 5; v++) begin
      int n;
      n = int'(vecs[v].n);
      clear_q();
      for (int b = 0; b < n; b++) send(vecs[v].in_kv[b], (b == n - 1));
      step();
      check("vec_in_ready_after_last", 32'(snap_in_ready), 0);
      check("vec_busy_in_drain", 32'(snap_busy), 1);
      wait_outputs(n);
      check("vec_count", 32'(oq_kv.size()), 32'(n));
      if (oq_kv.size() == n) begin
        check("vec_first_latency", 32'(oq_cyc[0] - last_hs_cyc), 2);
        for (int i = 0; i < n; i++) begin
          check($sformatf("vec%0d_kv%0d", v, i), 32'(oq_kv[i]), 32'(vecs[v].exp_kv[i]));
          check($sformatf("vec%0d_last%0d", v, i), 32'(oq_last[i]), 32'(i == n - 1));
          if (i > 0) check($sformatf("vec%0d_gap%0d", v, i), 32'(oq_cyc[i] - oq_cyc[i-1]), 1);
        end
      end
      step();
      check("vec_idle_busy", 32'(snap_busy), 0);
      check("vec_idle_out_valid", 32'(snap_out_valid), 0);
      check("vec_err_trunc", 32'(snap_err), 0);
    end

    // Equal keys: values must follow their own keys, tie order free
    clear_q();
    send(16'h0431, 1'b0);
    send(16'h0432, 1'b0);
    send(16'h0233, 1'b1);
    wait_outputs(3);
    check("dup_count", 32'(oq_kv.size()), 3);
    if (oq_kv.size() == 3) begin
      check("dup_first", 32'(oq_kv[0]), 32'h0233);
      check("dup_key1", 32'(oq_kv[1][15:8]), 4);
      check("dup_key2", 32'(oq_kv[2][15:8]), 4);
      check("dup_vals", 32'((oq_kv[1][7:0] == 8'h31 && oq_kv[2][7:0] == 8'h32) ||
                            (oq_kv[1][7:0] == 8'h32 && oq_kv[2][7:0] == 8'h31)), 1);
      check("dup_last", 32'({oq_last[0], oq_last[1], oq_last[2]}), 32'b001);
    end

    // Output backpressure: head entry held stable, no dequeue while stalled
    clear_q();
    out_ready = 1'b0;
    send(16'h0661, 1'b0);
    send(16'h0262, 1'b0);
    send(16'h0863, 1'b1);
    begin
      int t;
      t = 0;
      do begin
        step();
        t++;
      end while (!snap_out_valid && t < 50);
      if (!snap_out_valid) timeout_fail("stall_first_valid");
    end
    check("stall_kv_0", 32'(snap_out_kv), 32'h0262);
    check("stall_deq_0", 32'(snap_pq_deq), 0);
    for (int i = 1; i < 3; i++) begin
      step();
      check($sformatf("stall_valid_%0d", i), 32'(snap_out_valid), 1);
      check($sformatf("stall_kv_%0d", i), 32'(snap_out_kv), 32'h0262);
      check($sformatf("stall_deq_%0d", i), 32'(snap_pq_deq), 0);
    end
    out_ready = 1'b1;
    wait_outputs(3);
    check("stall_count", 32'(oq_kv.size()), 3);
    if (oq_kv.size() == 3) begin
      check("stall_out0", 32'(oq_kv[0]), 32'h0262);
      check("stall_out1", 32'(oq_kv[1]), 32'h0661);
      check("stall_out2", 32'(oq_kv[2]), 32'h0863);
      check("stall_last", 32'(oq_last[2]), 1);
    end

    // Truncation at capacity: 17 beats, no last
    clear_q();
    for (int i = 0; i < 15; i++) begin
      logic [7:0] k;
      k = 8'(((i * 7) % 15) + 1);
      send({k, k ^ 8'hA0}, 1'b0);
    end
    step();
    check("trunc_err_set", 32'(snap_err), 1);
    check("trunc_in_ready", 32'(snap_in_ready), 0);
    wait_outputs(15);
    check("trunc_count", 32'(oq_kv.size()), 15);
    if (oq_kv.size() == 15) begin
      for (int i = 0; i < 15; i++) begin
        logic [7:0] k;
        k = 8'(i + 1);
        check($sformatf("trunc_kv%0d", i), 32'(oq_kv[i]), 32'({k, k ^ 8'hA0}));
        check($sformatf("trunc_last%0d", i), 32'(oq_last[i]), 32'(i == 14));
      end
    end
    step();
    check("trunc_idle_busy", 32'(snap_busy), 0);
    check("trunc_err_sticky", 32'(snap_err), 1);
    clear_q();
    send(16'h1416, 1'b0);
    step();
    check("trunc_err_cleared", 32'(snap_err), 0);
    send(16'h0A17, 1'b1);
    wait_outputs(2);
    check("next_count", 32'(oq_kv.size()), 2);
    if (oq_kv.size() == 2) begin
      check("next_out0", 32'(oq_kv[0]), 32'h0A17);
      check("next_out1", 32'(oq_kv[1]), 32'h1416);
      check("next_last", 32'({oq_last[0], oq_last[1]}), 32'b01);
    end

    // PQ busy during load and during drain
    clear_q();
    send(16'h0551, 1'b0);
    send(16'h0152, 1'b0);
    in_valid = 1'b1;
    in_kv    = 16'h0453;
    in_last  = 1'b0;
    pq_busy  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("busy_load_ready%0d", i), 32'(snap_in_ready), 0);
      check($sformatf("busy_load_enq%0d", i), 32'(snap_pq_enq), 0);
    end
    pq_busy = 1'b0;
    send(16'h0453, 1'b0);
    send(16'h0254, 1'b1);
    wait_outputs(1);
    pq_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("busy_drain_deq%0d", i), 32'(snap_pq_deq), 0);
    end
    pq_busy = 1'b0;
    wait_outputs(4);
    check("busy_count", 32'(oq_kv.size()), 4);
    if (oq_kv.size() == 4) begin
      check("busy_out0", 32'(oq_kv[0]), 32'h0152);
      check("busy_out1", 32'(oq_kv[1]), 32'h0254);
      check("busy_out2", 32'(oq_kv[2]), 32'h0453);
      check("busy_out3", 32'(oq_kv[3]), 32'h0551);
      check("busy_last", 32'({oq_last[0], oq_last[1], oq_last[2], oq_last[3]}), 32'b0001);
    end

    // Asynchronous reset in the middle of a drain
    clear_q();
    send(16'h3201, 1'b0);
    send(16'h0A02, 1'b0);
    send(16'h2803, 1'b0);
    send(16'h1404, 1'b0);
    send(16'h1E05, 1'b1);
    wait_outputs(2);
    if (oq_kv.size() >= 2) begin
      check("mid_out0", 32'(oq_kv[0]), 32'h0A02);
      check("mid_out1", 32'(oq_kv[1]), 32'h1404);
    end
    check("mid_valid_before_rst", 32'(out_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_last", 32'(out_last), 0);
    check("arst_err_trunc", 32'(err_trunc), 0);
    check("arst_in_ready", 32'(in_ready), 0);
    check("arst_busy", 32'(busy), 0);
    step();
    step();
    rst = 1'b1;
    clear_q();
    step();
    check("post_rst_busy", 32'(snap_busy), 0);
    check("post_rst_in_ready", 32'(snap_in_ready), 1);
    check("post_rst_out_valid", 32'(snap_out_valid), 0);
    send(16'h0333, 1'b0);
    send(16'h0111, 1'b1);
    wait_outputs(2);
    check("post_rst_count", 32'(oq_kv.size()), 2);
    if (oq_kv.size() == 2) begin
      check("post_rst_out0", 32'(oq_kv[0]), 32'h0111);
      check("post_rst_out1", 32'(oq_kv[1]), 32'h0333);
      check("post_rst_last", 32'({oq_last[0], oq_last[1]}), 32'b01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pq_batch_sorter.md
Name: pq_batch_sorter

Overview:
- Host-side initiator of the priority-queue device interface: the end that drives enq/deq/kvi and consumes kvo/full/empty/busy.
- Accepts a batch of key/value beats on a valid/ready input stream and enqueues each into the attached PQ.
- At end of batch, dequeues the PQ until empty and emits the entries in ascending key order on a valid/ready output stream.
- Sits between a stream producer and the quickq-style PQ instance; it turns the PQ into a streaming batch sorter.

Parameters:
KEY_WIDTH, 8, key field width (matches pq_pkg)
VAL_WIDTH, 8, value field width (matches pq_pkg)
PQ_CAPACITY, 15, max entries of attached PQ; batch truncation limit

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&&in_ready
in_kv  in  KEY_WIDTH+VAL_WIDTH  input entry {key,val}, key in MSBs
in_last  in  1  final beat of batch
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_kv  out  KEY_WIDTH+VAL_WIDTH  sorted entry
out_last  out  1  final entry of batch
pq_enq  out  1  PQ enqueue command
pq_deq  out  1  PQ dequeue command
pq_kvi  out  KEY_WIDTH+VAL_WIDTH  entry to enqueue
pq_kvo  in  KEY_WIDTH+VAL_WIDTH  PQ head (min key), valid when !pq_empty
pq_full  in  1  PQ full
pq_empty  in  1  PQ empty
pq_busy  in  1  PQ not ready for a command this cycle
err_trunc  out  1  sticky: current batch was truncated at PQ_CAPACITY
busy  out  1  high whenever not in LOAD with count==0

Behaviour:
- Reset (rst low, async): state=LOAD, count=0, out_valid=0, out_last=0, out_kv=0, err_trunc=0, pq_enq=0, pq_deq=0. in_ready is combinational and therefore 0 while held in reset. PQ shares rst; contents are lost mid-batch with no recovery.
- count: $clog2(PQ_CAPACITY+1) bits. It holds the number of entries enqueued in the current batch and never wraps.
- LOAD state:
  - in_ready = !pq_busy && !pq_full && count<PQ_CAPACITY.
  - pq_enq = in_valid && in_ready. pq_kvi = in_kv (combinational passthrough). pq_deq=0.
  - On each handshake: count++. The first handshake of a batch clears err_trunc.
  - Handshake with in_last=1 -> DRAIN.
  - Handshake that makes count==PQ_CAPACITY without in_last -> DRAIN and set err_trunc. Later beats belong to the next batch.
- DRAIN state:
  - in_ready=0, pq_enq=0.
  - Output register is one entry (out_kv/out_valid/out_last).
  - pq_deq = count!=0 && !pq_busy && !pq_empty && (!out_valid || out_ready). Same cycle, out_kv<=pq_kvo, out_valid<=1, count--, out_last<=(count==1).
  - Output handshake without a new pq_deq: out_valid<=0.
  - Sustained throughput is 1 entry/cycle when the PQ allows it.
  - Output handshake with out_last=1 -> LOAD. count is already 0; out_valid and out_last clear.
  - pq_empty with count!=0: stall (no deq, no output). This never occurs with a conforming PQ.
- Never assert pq_enq and pq_deq together; replace is unused.
- out_kv, out_valid, out_last are stable while out_valid && !out_ready.
- Latency: out_valid rises at the earliest 2 cycles after the last-beat handshake (edge 1: enq and ->DRAIN; edge 2: deq capture), assuming pq_busy=0.
- Ordering: ascending key. Order among equal keys is unspecified; values must travel with their keys.
- busy=0 only in LOAD with count==0.

Test Plan:
1. Keys {9,3,7,1,5} with vals {A..E}, in_last on the 5th beat, out_ready=1 -> out keys 1,3,5,7,9 on consecutive cycles with vals {D,B,E,C,A}; out_last only on key 9; first out_valid 2 cycles after the last handshake; in_ready=0 throughout drain.
2. Keys {4,4,2} vals {x1,x2,x3} -> key 2/x3 first, then the two key-4 entries in either order, each paired with its own val; out_last on the 3rd entry.
3. Drain of {6,2,8} with out_ready low for 3 cycles after first valid -> out_kv holds 2 stably, no pq_deq during the stall, then 6,8 follow once ready returns.
4. PQ_CAPACITY=15, 17 beats with no in_last -> 15 sorted outputs with out_last on the 15th and err_trunc=1. Beats 16-17 form the next batch; err_trunc clears on beat 16's handshake.
5. pq_busy forced high for 2 cycles during LOAD and again during DRAIN -> in_ready=0 and pq_deq=0 in those cycles, no beats lost, correct sort order.
6. Assert rst low mid-drain after 2 of 5 outputs -> out_valid/out_last/err_trunc=0 immediately (async); after release, state LOAD, count=0, a new batch {3,1} sorts to 1,3.
